alarm_controller: RTL
=====================

Name: alarm_controller

Overview:
Sequential arm/disarm controller downstream of the 2-of-3 sensor voter; consumes the voter's output Y on input trig.
Drives the siren and the status LED through a five-state Moore FSM with exit, entry and siren-timeout timers.
Sits between the combinational voter and the board's siren/LED pins.

Parameters:
EXIT_CYCLES, 16, cycles spent in EXIT_DELAY before arming (>=1)
ENTRY_CYCLES, 8, cycles spent in ENTRY_DELAY before alarm (>=1)
ALARM_CYCLES, 32, maximum cycles siren stays on before auto re-arm (>=1)
BLINK_CYCLES, 4, half-period of status LED blink in cycles (>=1)

Ports:
clk  input  1  system clock, all logic on rising edge
rst_n  input  1  synchronous active-low reset
arm_sw  input  1  arm switch level, already synchronized: 1 = armed request, 0 = disarm
trig  input  1  voter output Y (1 = at least two sensors active), synchronous level
siren  output  1  siren drive, 1 only in ALARM
led_status  output  1  status LED (see Behaviour)
state_o  output  3  current state code

Behaviour:
- Reset: rst_n sampled low at rising edge -> state DISARMED, siren=0, led_status=0, state_o=0, timer=0, blink counter=0, blink phase=0; overrides all other inputs, also mid-delay or mid-alarm.
- State codes: DISARMED=0, EXIT_DELAY=1, ARMED=2, ENTRY_DELAY=3, ALARM=4; codes 5-7 unreachable, decode to DISARMED on next edge.
- Moore outputs decoded from registered state; no combinational path from inputs to outputs.
- Global priority: arm_sw=0 in any state except DISARMED -> DISARMED next edge, regardless of trig/timer.
- DISARMED: arm_sw=1 -> EXIT_DELAY, timer loads EXIT_CYCLES-1.
- EXIT_DELAY: trig ignored; timer decrements each cycle; at timer==0 -> ARMED. State occupies exactly EXIT_CYCLES cycles.
- ARMED: trig=1 -> ENTRY_DELAY, timer loads ENTRY_CYCLES-1.
- ENTRY_DELAY: trig ignored (already latched); timer==0 -> ALARM, timer loads ALARM_CYCLES-1. Exactly ENTRY_CYCLES cycles.
- ALARM: siren=1; timer==0 -> ARMED, siren=0. If trig still 1 in ARMED, re-enters ENTRY_DELAY next edge (level retrigger is intended).
- Timer width: $clog2 of the max of the three cycle parameters, plus 1; unsigned; never wraps (load precedes underflow).
- led_status: DISARMED 0; ARMED 1; ALARM 1; EXIT_DELAY/ENTRY_DELAY blink. Blink phase toggles every BLINK_CYCLES cycles. On entry to a delay state: blink counter=0 and phase=1, so LED is on the first cycle. Counter and phase cleared in non-delay states.
- Simultaneous events: arm_sw=0 together with trig=1 or timer expiry -> DISARMED wins. ARMED with trig=1 and arm_sw=1 -> ENTRY_DELAY.
- Latency: input change sampled at edge N is reflected in state_o/siren/led_status after edge N (1 cycle).

Optional Feature:
Macro ALARM_EVENT_CNT_EN.
- Defined: adds output port alarm_count [7:0]. Increments by 1 on each transition into ALARM; saturates at 255; cleared to 0 only by reset, not by disarm.
- Undefined: port and counter absent; all other behaviour identical.

Test Plan:
- Reset hold 3 cycles with arm_sw=1, trig=1 -> state_o=0, siren=0, led_status=0 throughout; after release, state_o=1 one edge later.
- arm_sw rises, trig=0 -> state_o=1 for exactly 16 cycles, led_status pattern 1111 0000 1111 0000, then state_o=2, led_status=1.
- ARMED, trig pulse 1 cycle -> state_o=3 for 8 cycles, then state_o=4, siren=1 for exactly 32 cycles, then state_o=2, siren=0. With ALARM_EVENT_CNT_EN, alarm_count=1.
- ALARM, arm_sw=0 on cycle 5 of siren -> next edge state_o=0, siren=0, led_status=0. Same test in ENTRY_DELAY cycle 3 and EXIT_DELAY cycle 10 -> state_o=0.
- trig held 1 through alarm timeout -> ALARM(32) -> ARMED(1 cycle) -> ENTRY_DELAY(8) -> ALARM again. With macro, count reaches 2.
- Macro defined, force 300 alarm cycles using all parameters=1 -> alarm_count saturates at 255 and holds; disarm/re-arm does not clear it; rst_n low clears it to 0.

Source files
------------

// File: rtl/alarm_controller_if.sv
// Board-side signal bundle for the alarm controller.
// master: the driver of arm switch / voter output (board or bench).
// slave : the controller itself.
// Optional ALARM_EVENT_CNT_EN adds the alarm_count observation bus.
interface alarm_controller_if;
   logic       arm_sw;
   logic       trig;
   logic       siren;
   logic       led_status;
   logic [2:0] state_o;
`ifdef ALARM_EVENT_CNT_EN
   logic [7:0] alarm_count;

   modport master (
      output arm_sw, trig,
      input  siren, led_status, state_o, alarm_count
   );

   modport slave (
      input  arm_sw, trig,
      output siren, led_status, state_o, alarm_count
   );
`else
   modport master (
      output arm_sw, trig,
      input  siren, led_status, state_o
   );

   modport slave (
      input  arm_sw, trig,
      output siren, led_status, state_o
   );
`endif
endinterface

// File: rtl/alarm_controller.sv
// Arm/disarm controller fed by the 2-of-3 sensor voter (trig).
// Five-state Moore FSM with exit, entry and siren-timeout timers and a
// blinking status LED during the delay states.
// Optional feature macro: ALARM_EVENT_CNT_EN adds a saturating 8-bit count
// of transitions into ALARM, cleared only by reset.
module alarm_controller #(
   parameter int EXIT_CYCLES  = 16,
   parameter int ENTRY_CYCLES = 8,
   parameter int ALARM_CYCLES = 32,
   parameter int BLINK_CYCLES = 4
) (
   input logic              clk,
   input logic              rst_n,
   alarm_controller_if.slave bus
);

   // State codes are externally visible on state_o; keep them fixed.
   localparam logic [2:0] DISARMED    = 3'd0;
   localparam logic [2:0] EXIT_DELAY  = 3'd1;
   localparam logic [2:0] ARMED       = 3'd2;
   localparam logic [2:0] ENTRY_DELAY = 3'd3;
   localparam logic [2:0] ALARM       = 3'd4;

   localparam int MAX_XE  = (EXIT_CYCLES > ENTRY_CYCLES) ? EXIT_CYCLES : ENTRY_CYCLES;
   localparam int MAX_CYC = (MAX_XE > ALARM_CYCLES) ? MAX_XE : ALARM_CYCLES;
   localparam int TW      = $clog2(MAX_CYC) + 1;
   localparam int BW      = $clog2(BLINK_CYCLES + 1);

   localparam logic [TW-1:0] EXIT_LD    = TW'(EXIT_CYCLES - 1);
   localparam logic [TW-1:0] ENTRY_LD   = TW'(ENTRY_CYCLES - 1);
   localparam logic [TW-1:0] ALARM_LD   = TW'(ALARM_CYCLES - 1);
   localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK_CYCLES - 1);

   logic [2:0]    state, state_nxt;
   logic [TW-1:0] timer, timer_nxt;
   logic [BW-1:0] blink_cnt, blink_cnt_nxt;
   logic          blink_ph, blink_ph_nxt;
   logic          timer_done;

   assign timer_done = (timer == '0);

   // Next-state and timer: disarm has priority over everything else; each
   // delay/alarm state loads its timer on entry and leaves when it hits zero,
   // so the timer is reloaded before it could ever underflow.
   always_comb begin
      state_nxt = DISARMED;
      timer_nxt = '0;
      if (bus.arm_sw) begin
         case (state)
            DISARMED: begin
               state_nxt = EXIT_DELAY;
               timer_nxt = EXIT_LD;
            end
            EXIT_DELAY: begin
               if (timer_done) begin
                  state_nxt = ARMED;
               end else begin
                  state_nxt = EXIT_DELAY;
                  timer_nxt = timer - TW'(1);
               end
            end
            ARMED: begin
               if (bus.trig) begin
                  state_nxt = ENTRY_DELAY;
                  timer_nxt = ENTRY_LD;
               end else begin
                  state_nxt = ARMED;
               end
            end
            ENTRY_DELAY: begin
               if (timer_done) begin
                  state_nxt = ALARM;
                  timer_nxt = ALARM_LD;
               end else begin
                  state_nxt = ENTRY_DELAY;
                  timer_nxt = timer - TW'(1);
               end
            end
            ALARM: begin
               // Back to ARMED on timeout; a still-active trig re-enters
               // ENTRY_DELAY from there on the following edge.
               if (timer_done) begin
                  state_nxt = ARMED;
               end else begin
                  state_nxt = ALARM;
                  timer_nxt = timer - TW'(1);
               end
            end
            default: begin
               // Unreachable codes 5-7 recover to DISARMED.
               state_nxt = DISARMED;
               timer_nxt = '0;
            end
         endcase
      end
   end

   // Blink generator: restarts with LED on when a delay state is entered,
   // toggles phase every BLINK_CYCLES cycles, idles cleared elsewhere.
   always_comb begin
      blink_cnt_nxt = '0;
      blink_ph_nxt  = 1'b0;
      if (state_nxt == EXIT_DELAY || state_nxt == ENTRY_DELAY) begin
         if (state_nxt != state) begin
            blink_cnt_nxt = '0;
            blink_ph_nxt  = 1'b1;
         end else if (blink_cnt == BLINK_LAST) begin
            blink_cnt_nxt = '0;
            blink_ph_nxt  = ~blink_ph;
         end else begin
            blink_cnt_nxt = blink_cnt + BW'(1);
            blink_ph_nxt  = blink_ph;
         end
      end
   end

   // State, timer and blink registers with synchronous active-low reset.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state     <= DISARMED;
         timer     <= '0;
         blink_cnt <= '0;
         blink_ph  <= 1'b0;
      end else begin
         state     <= state_nxt;
         timer     <= timer_nxt;
         blink_cnt <= blink_cnt_nxt;
         blink_ph  <= blink_ph_nxt;
      end
   end

   // Moore output decode from registered state only.
   always_comb begin
      bus.state_o    = state;
      bus.siren      = (state == ALARM);
      bus.led_status = 1'b0;
      case (state)
         ARMED, ALARM:            bus.led_status = 1'b1;
         EXIT_DELAY, ENTRY_DELAY: bus.led_status = blink_ph;
         default:                 bus.led_status = 1'b0;
      endcase
   end

`ifdef ALARM_EVENT_CNT_EN
   logic [7:0] alarm_count;

   // Count entries into ALARM, saturating; disarm does not clear it.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         alarm_count <= 8'd0;
      end else if (state_nxt == ALARM && state != ALARM && alarm_count != 8'hFF) begin
         alarm_count <= alarm_count + 8'd1;
      end
   end

   assign bus.alarm_count = alarm_count;
`endif

endmodule
